// File: rtl/host_of_verifla_pkg.sv
// Shared analyzer configuration: command bytes exchanged with the
// analyzer core and the host FSM state type.
package host_of_verifla_pkg;

  // Command bytes understood by computer_input_of_verifla.
  localparam logic [7:0] CMD_RESET = 8'h00;
  localparam logic [7:0] CMD_RUN   = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_CMD  = 3'd1,
    ST_WAIT_TX   = 3'd2,
    ST_RECV_WORD = 3'd3,
    ST_WRITE     = 3'd4,
    ST_RECV_TAIL = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERR       = 3'd7
  } state_t;

  // Number of whole bytes needed to carry a field of the given bit width.
  function automatic int bytes_for_bits(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/host_rx_timer_of_verifla.sv
// Inter-byte timeout counter. Counts enabled cycles since the last clear
// and flags the terminal count LIMIT-1, where it holds until cleared.
module host_rx_timer_of_verifla #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  // Clear has priority so a byte arriving on the terminal cycle reloads.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign terminal = (cnt == LAST);

endmodule

// File: rtl/host_of_verifla.sv
// Host-side protocol engine for the logic analyzer. Sends RUN/RESET command
// bytes, reassembles the capture dump into words written to a local buffer,
// and latches the trailing queue-tail address. Every output is registered.
//
// Handshakes: tx_start, tx_done, rx_ready and buf_wen are single-cycle
// strobes; the accompanying data bus is valid only in the strobe cycle and
// there is no back-pressure in either direction.
module host_of_verifla
  import host_of_verifla_pkg::*;
#(
  parameter int MEM_ADDR_BITS  = 8,
  parameter int WORD_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic                      start,
  input  logic                      reset_cmd,
  output logic [7:0]                tx_data,
  output logic                      tx_start,
  input  logic                      tx_done,
  input  logic [7:0]                rx_data,
  input  logic                      rx_ready,
  output logic [MEM_ADDR_BITS-1:0]  buf_addr,
  output logic [8*WORD_BYTES-1:0]   buf_data,
  output logic                      buf_wen,
  output logic [MEM_ADDR_BITS-1:0]  tail_addr,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout_err,
  output state_t                    fsm_state
);

  localparam int WORD_W     = 8 * WORD_BYTES;
  localparam int TAIL_BYTES = bytes_for_bits(MEM_ADDR_BITS);
  localparam int MAX_BYTES  = (WORD_BYTES > TAIL_BYTES) ? WORD_BYTES : TAIL_BYTES;
  localparam int SHIFT_W    = 8 * MAX_BYTES;
  localparam int CNT_W      = $clog2(MAX_BYTES + 1);

  localparam logic [CNT_W-1:0]         WORD_LAST = CNT_W'(WORD_BYTES - 1);
  localparam logic [CNT_W-1:0]         TAIL_LAST = CNT_W'(TAIL_BYTES - 1);
  localparam logic [MEM_ADDR_BITS-1:0] ADDR_MAX  = '1;

  state_t                     state, state_n;
  logic                       cmd_run, cmd_run_n;
  logic [CNT_W-1:0]           byte_cnt, byte_cnt_n;
  logic [SHIFT_W-1:0]         shreg, shreg_n;
  logic [SHIFT_W-1:0]         shifted;
  logic [7:0]                 tx_data_n;
  logic                       tx_start_n;
  logic [MEM_ADDR_BITS-1:0]   buf_addr_n;
  logic [WORD_W-1:0]          buf_data_n;
  logic                       buf_wen_n;
  logic [MEM_ADDR_BITS-1:0]   tail_addr_n;
  logic                       busy_n;
  logic                       done_n;
  logic                       timeout_err_n;
  logic                       rx_active;
  logic                       timer_terminal;

  assign fsm_state = state;

  // Bytes arrive MSB first, so each new byte enters at the bottom.
  assign shifted = SHIFT_W'({shreg, rx_data});

  // The timeout only applies while download bytes are expected.
  assign rx_active = (state == ST_RECV_WORD) || (state == ST_WRITE) ||
                     (state == ST_RECV_TAIL);

  host_rx_timer_of_verifla #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_rx_timer (
    .clk      (clk),
    .rst_l    (rst_l),
    .clear    (rx_ready || !rx_active),
    .enable   (rx_active),
    .terminal (timer_terminal)
  );

  // Next-state and next-output logic for the protocol FSM.
  always_comb begin
    state_n       = state;
    cmd_run_n     = cmd_run;
    byte_cnt_n    = byte_cnt;
    shreg_n       = shreg;
    tx_data_n     = tx_data;
    tx_start_n    = 1'b0;
    buf_addr_n    = buf_addr;
    buf_data_n    = buf_data;
    buf_wen_n     = 1'b0;
    tail_addr_n   = tail_addr;
    done_n        = done;
    timeout_err_n = timeout_err;

    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        // reset_cmd wins over start when both arrive together.
        if (reset_cmd || start) begin
          state_n       = ST_SEND_CMD;
          cmd_run_n     = !reset_cmd;
          tx_data_n     = reset_cmd ? CMD_RESET : CMD_RUN;
          tx_start_n    = 1'b1;
          done_n        = 1'b0;
          timeout_err_n = 1'b0;
        end
      end

      ST_SEND_CMD: begin
        state_n = ST_WAIT_TX;
      end

      ST_WAIT_TX: begin
        if (tx_done) begin
          if (cmd_run) begin
            buf_addr_n = '0;
            byte_cnt_n = '0;
            state_n    = ST_RECV_WORD;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end

      ST_RECV_WORD: begin
        if (rx_ready) begin
          shreg_n = shifted;
          if (byte_cnt == WORD_LAST) begin
            buf_data_n = shifted[WORD_W-1:0];
            buf_wen_n  = 1'b1;
            byte_cnt_n = '0;
            state_n    = ST_WRITE;
          end else begin
            byte_cnt_n = byte_cnt + CNT_W'(1);
          end
        end else if (timer_terminal) begin
          timeout_err_n = 1'b1;
          state_n       = ST_ERR;
        end
      end

      ST_WRITE: begin
        // The write itself happens this cycle; pick the next phase and
        // treat a byte arriving now as the first byte of that phase.
        buf_addr_n = buf_addr + MEM_ADDR_BITS'(1);
        byte_cnt_n = '0;
        state_n    = (buf_addr == ADDR_MAX) ? ST_RECV_TAIL : ST_RECV_WORD;
        if (rx_ready) begin
          shreg_n = shifted;
          if (buf_addr == ADDR_MAX) begin
            if (TAIL_BYTES == 1) begin
              tail_addr_n = shifted[MEM_ADDR_BITS-1:0];
              done_n      = 1'b1;
              state_n     = ST_DONE;
            end else begin
              byte_cnt_n = CNT_W'(1);
            end
          end else begin
            if (WORD_BYTES == 1) begin
              buf_data_n = shifted[WORD_W-1:0];
              buf_wen_n  = 1'b1;
              state_n    = ST_WRITE;
            end else begin
              byte_cnt_n = CNT_W'(1);
            end
          end
        end else if (timer_terminal) begin
          timeout_err_n = 1'b1;
          state_n       = ST_ERR;
        end
      end

      ST_RECV_TAIL: begin
        if (rx_ready) begin
          shreg_n = shifted;
          if (byte_cnt == TAIL_LAST) begin
            tail_addr_n = shifted[MEM_ADDR_BITS-1:0];
            done_n      = 1'b1;
            byte_cnt_n  = '0;
            state_n     = ST_DONE;
          end else begin
            byte_cnt_n = byte_cnt + CNT_W'(1);
          end
        end else if (timer_terminal) begin
          timeout_err_n = 1'b1;
          state_n       = ST_ERR;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = !((state_n == ST_IDLE) || (state_n == ST_DONE) || (state_n == ST_ERR));
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= ST_IDLE;
      cmd_run     <= 1'b0;
      byte_cnt    <= '0;
      shreg       <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
      buf_wen     <= 1'b0;
      tail_addr   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cmd_run     <= cmd_run_n;
      byte_cnt    <= byte_cnt_n;
      shreg       <= shreg_n;
      tx_data     <= tx_data_n;
      tx_start    <= tx_start_n;
      buf_addr    <= buf_addr_n;
      buf_data    <= buf_data_n;
      buf_wen     <= buf_wen_n;
      tail_addr   <= tail_addr_n;
      busy        <= busy_n;
      done        <= done_n;
      timeout_err <= timeout_err_n;
    end
  end

endmodule

// File: tb/tb_host_of_verifla.sv
// Bench for host_of_verifla with a small capture (4 words of 2 bytes,
// one tail byte) and a short inter-byte timeout.
module tb_host_of_verifla;
  import host_of_verifla_pkg::*;

  localparam int MAB    = 2;
  localparam int WB     = 2;
  localparam int TO     = 16;
  localparam int W      = 8 * WB;
  localparam int NWORDS = 4;
  localparam int NBYTES = NWORDS * WB + 1;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst_l;
  logic           start, reset_cmd, tx_done, rx_ready;
  logic [7:0]     rx_data;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic [MAB-1:0] buf_addr;
  logic [W-1:0]   buf_data;
  logic           buf_wen;
  logic [MAB-1:0] tail_addr;
  logic           busy, done, timeout_err;
  state_t         fsm_state;

  always #5 clk = ~clk;

  host_of_verifla #(
    .MEM_ADDR_BITS  (MAB),
    .WORD_BYTES     (WB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .start       (start),
    .reset_cmd   (reset_cmd),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .buf_addr    (buf_addr),
    .buf_data    (buf_data),
    .buf_wen     (buf_wen),
    .tail_addr   (tail_addr),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .fsm_state   (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [MAB+W-1:0] exp_q[$];
  logic [MAB+W-1:0] obs_wr_q[$];
  logic [7:0]       obs_tx_q[$];
  logic [7:0]       dl_bytes[NBYTES];
  int               gaps[NBYTES];
  logic [MAB-1:0]   exp_tail;

  // Record every buffer write and every command byte sent.
  always @(negedge clk) begin
    if (buf_wen) obs_wr_q.push_back({buf_addr, buf_data});
    if (tx_start) obs_tx_q.push_back(tx_data);
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_reset_cmd();
    reset_cmd = 1'b1;
    @(posedge clk); #1;
    reset_cmd = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic random_bytes();
    for (int i = 0; i < NBYTES; i++) dl_bytes[i] = 8'($urandom_range(0, 255));
  endtask

  // Full RUN download of dl_bytes. gap_mode: 0 back-to-back,
  // 1 random short gaps, 2 some gaps landing on the terminal timeout cycle.
  task automatic do_download(input int gap_mode, input string tag);
    exp_q.delete();
    obs_wr_q.delete();
    obs_tx_q.delete();
    // Reference: word k is bytes 2k,2k+1 MSB first at address k; the
    // tail byte's low address bits give tail_addr.
    for (int k = 0; k < NWORDS; k++)
      exp_q.push_back({MAB'(k), dl_bytes[WB*k], dl_bytes[WB*k+1]});
    exp_tail = dl_bytes[NBYTES-1][MAB-1:0];
    for (int i = 0; i < NBYTES; i++) begin
      if (gap_mode == 0) gaps[i] = 0;
      else if (gap_mode == 1) gaps[i] = int'($urandom_range(0, 3));
      else gaps[i] = (i % 3 == 1) ? TO - 1 : int'($urandom_range(0, 2));
    end

    pulse_start();
    n_checks++;
    if ({tx_start, tx_data, busy, done, timeout_err} !== {1'b1, CMD_RUN, 1'b1, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL %s start_accept got start=%b data=%h busy=%b done=%b to=%b want 1 01 1 0 0",
               tag, tx_start, tx_data, busy, done, timeout_err);
    end
    idle(4);
    pulse_tx_done();

    for (int i = 0; i < NBYTES; i++) begin
      send_byte(dl_bytes[i]);
      if ((i % WB == WB - 1) && (i < NBYTES - 1)) begin
        n_checks++;
        if ({buf_wen, buf_addr, buf_data} !== {1'b1, exp_q[i/WB]}) begin
          n_errors++;
          $display("FAIL %s write_timing byte%0d got wen=%b addr=%0d data=%h want 1 %h",
                   tag, i, buf_wen, buf_addr, buf_data, exp_q[i/WB]);
        end
      end
      if (i < NBYTES - 1) idle(gaps[i]);
    end

    n_checks++;
    if ({done, busy, timeout_err, tail_addr} !== {1'b1, 1'b0, 1'b0, exp_tail}) begin
      n_errors++;
      $display("FAIL %s finish got done=%b busy=%b to=%b tail=%0d want 1 0 0 %0d",
               tag, done, busy, timeout_err, tail_addr, exp_tail);
    end
    idle(2);
    n_checks++;
    if (obs_wr_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL %s write_count got %0d want %0d", tag, obs_wr_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (obs_wr_q[k] !== exp_q[k]) begin
          n_errors++;
          $display("FAIL %s write%0d got %h want %h", tag, k, obs_wr_q[k], exp_q[k]);
        end
      end
    end
    n_checks++;
    if (obs_tx_q.size() != 1 || obs_tx_q[0] !== CMD_RUN) begin
      n_errors++;
      $display("FAIL %s tx_cmds got count=%0d first=%h want 1 x 01",
               tag, obs_tx_q.size(), (obs_tx_q.size() > 0) ? obs_tx_q[0] : 8'hxx);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_l = 1'b0; start = 1'b0; reset_cmd = 1'b0; tx_done = 1'b0;
    rx_ready = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({tx_data, tx_start, buf_addr, buf_data, buf_wen, tail_addr, busy, done, timeout_err} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got %h want 0",
               {tx_data, tx_start, buf_addr, buf_data, buf_wen, tail_addr, busy, done, timeout_err});
    end
    @(negedge clk);
    rst_l = 1'b1;
    idle(2);
    n_checks++;
    if ({busy, done, timeout_err, tx_start, buf_wen} !== 5'b0) begin
      n_errors++;
      $display("FAIL post_reset_idle got %b want 00000", {busy, done, timeout_err, tx_start, buf_wen});
    end
  endtask

  task automatic test_run_download();
    dl_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h03};
    do_download(1, "run_fixed");
    for (int r = 0; r < 3; r++) begin
      random_bytes();
      do_download(1, "run_random");
    end
  endtask

  task automatic test_reset_cmd();
    obs_wr_q.delete();
    obs_tx_q.delete();
    pulse_reset_cmd();
    n_checks++;
    if ({tx_start, tx_data, busy, done} !== {1'b1, CMD_RESET, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_cmd_accept got start=%b data=%h busy=%b done=%b want 1 00 1 0",
               tx_start, tx_data, busy, done);
    end
    idle(4);
    pulse_tx_done();
    idle(1);
    n_checks++;
    if ({busy, done, timeout_err} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_cmd_idle got busy=%b done=%b to=%b want 0 0 0", busy, done, timeout_err);
    end
    n_checks++;
    if (obs_wr_q.size() != 0 || obs_tx_q.size() != 1) begin
      n_errors++;
      $display("FAIL reset_cmd_traffic got writes=%0d cmds=%0d want 0 1", obs_wr_q.size(), obs_tx_q.size());
    end
  endtask

  task automatic test_simultaneous();
    obs_wr_q.delete();
    obs_tx_q.delete();
    start = 1'b1;
    reset_cmd = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reset_cmd = 1'b0;
    n_checks++;
    if ({tx_start, tx_data} !== {1'b1, CMD_RESET}) begin
      n_errors++;
      $display("FAIL simul_priority got start=%b data=%h want 1 00", tx_start, tx_data);
    end
    idle(1);
    pulse_start();
    n_checks++;
    if (tx_start !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_start_ignored got tx_start=%b want 0", tx_start);
    end
    idle(2);
    pulse_tx_done();
    idle(2);
    n_checks++;
    if (obs_tx_q.size() != 1 || obs_tx_q[0] !== CMD_RESET || obs_wr_q.size() != 0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL simul_traffic got cmds=%0d writes=%0d busy=%b want 1 0 0",
               obs_tx_q.size(), obs_wr_q.size(), busy);
    end
  endtask

  task automatic test_idle_rx();
    obs_wr_q.delete();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));
    idle(2);
    n_checks++;
    if (obs_wr_q.size() != 0 || {busy, done, timeout_err} !== 3'b000) begin
      n_errors++;
      $display("FAIL idle_rx_ignored got writes=%0d busy=%b done=%b to=%b want 0 0 0 0",
               obs_wr_q.size(), busy, done, timeout_err);
    end
    random_bytes();
    do_download(1, "after_idle_rx");
  endtask

  task automatic test_timeout();
    logic [7:0] b0, b1, b2;
    int n;
    b0 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    obs_wr_q.delete();
    pulse_start();
    idle(4);
    pulse_tx_done();
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (timeout_err === 1'b1) begin
        n = c;
        break;
      end
    end
    n_checks++;
    if (n != TO) begin
      n_errors++;
      $display("FAIL timeout_latency got %0d cycles want %0d (0 = never)", n, TO);
    end
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_errors++;
      $display("FAIL timeout_state got busy=%b done=%b want 0 0", busy, done);
    end
    idle(3);
    n_checks++;
    if (obs_wr_q.size() != 1 || obs_wr_q[0] !== {MAB'(0), b0, b1}) begin
      n_errors++;
      $display("FAIL timeout_writes got count=%0d want 1 write of %h", obs_wr_q.size(), {MAB'(0), b0, b1});
    end
    // A new start must clear the sticky error (checked inside do_download).
    random_bytes();
    do_download(1, "after_timeout");
  endtask

  task automatic test_boundary();
    random_bytes();
    do_download(2, "terminal_cycle_byte");
    random_bytes();
    do_download(0, "back_to_back");
  endtask

  task automatic test_async_reset();
    random_bytes();
    pulse_start();
    idle(4);
    pulse_tx_done();
    for (int i = 0; i < 2 * WB; i++) send_byte(dl_bytes[i]);
    idle(1);
    #2;
    rst_l = 1'b0;
    #1;
    n_checks++;
    if ({tx_data, tx_start, buf_addr, buf_data, buf_wen, tail_addr, busy, done, timeout_err} !== '0) begin
      n_errors++;
      $display("FAIL async_reset_outputs got %h want 0",
               {tx_data, tx_start, buf_addr, buf_data, buf_wen, tail_addr, busy, done, timeout_err});
    end
    @(negedge clk);
    rst_l = 1'b1;
    idle(2);
    random_bytes();
    do_download(1, "after_async_reset");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_run_download();
    test_reset_cmd();
    test_simultaneous();
    test_idle_rx();
    test_timeout();
    test_boundary();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
